icache_fill: RTL and testbench
==============================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 Parameter: LINES, 8, number of direct-mapped lines (power of 2, 2..64); line = 8 words of 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 cpureq  input  1  CPU fetch request; level, held with pc stable until cpuready.
REQ-005 pc  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 cpuready  output  1  one-cycle pulse: cpuinstr valid for this request.
REQ-007 cpuinstr  output  32  fetched instruction word.
REQ-008 flush  input  1  invalidate all lines.
REQ-009 instrreq  output  1  burst request to the memory stage, held high for the whole fill.
REQ-010 instradr  output  32  line-aligned burst base, {pc[31:5],5'b0}.
REQ-011 instrval  input  1  memory beat valid, one word per cycle.
REQ-012 instr  input  32  memory beat data; beats arrive in ascending word order.
REQ-013 misscnt  output  16  saturating count of completed fills.

Function
REQ-014 Address split: offset = pc[4:2], index = pc[4+log2(LINES):5], tag = remaining upper bits.
REQ-015 Storage: data array LINES x 8 x 32, tag array, one valid bit per line.
REQ-016 FSM states: IDLE, FILL.
REQ-017 IDLE, cpureq=1, hit (valid and tag match) -> next edge: cpuready<=1, cpuinstr<=data[index][offset]; stay IDLE.
REQ-018 cpuready is high for exactly one cycle per hit; if cpureq is still high in that cycle, it is a new request.
REQ-019 IDLE, cpureq=1, miss -> next edge: state FILL, instrreq<=1, instradr<=line base, beat counter<=0, cpuready stays 0.
REQ-020 FILL: each edge with instrval=1 writes instr into data[index][beat] and increments beat (3 bits).
REQ-021 FILL: instrval is ignored outside FILL; in FILL it is only an enable, never sampled as X-tolerant data.
REQ-022 Edge writing beat 7: instrreq<=0, valid[index]<=1, tag[index]<=tag, misscnt+=1 (holds at 16'hFFFF), state<=IDLE.
REQ-023 Memory protocol timing: memory samples instrreq one edge after assertion, delivers 8 beats on the following 8 edges, and terminates its burst on the edge where the cache drops instrreq; instrreq is high for exactly 10 edges per fill.
REQ-024 After a fill, request re-evaluates in IDLE and hits; miss-to-cpuready latency = 12 cycles from first sampling of cpureq.
REQ-025 pc and cpureq are not re-sampled during FILL; index/tag/offset latched at the miss edge.
REQ-026 flush in IDLE: all valid bits <=0 on that edge; a simultaneous cpureq is treated as a miss.
REQ-027 flush in FILL: latched as pending; applied on the edge after fill completes, before the re-lookup, so that request misses again.
REQ-028 flush does not alter data/tag arrays or misscnt.
REQ-029 Tag compare is full width; no partial-tag aliasing allowed.

Reset
REQ-030 reset=1 on an edge: state IDLE, instrreq=0, instradr=0, cpuready=0, cpuinstr=0, misscnt=0, all valid=0, beat=0, pending flush=0.
REQ-031 Reset mid-FILL aborts the fill; partial line stays invalid; memory stage burst counter is reset by the system reset, not by this block.
REQ-032 Data and tag arrays are not reset.

Verification
REQ-033 Cold miss: reset, cpureq=1 pc=32'h0000_0044, memory returns 32'h1000_0000+k for beat k -> instradr=32'h40, instrreq high 10 edges, cpuready after 12 cycles with cpuinstr=32'h1000_0001, misscnt=1.
REQ-034 Hit: then pc=32'h0000_005C -> cpuready next cycle, cpuinstr=32'h1000_0007, instrreq stays 0, misscnt=1.
REQ-035 Conflict: LINES=8, pc=32'h0000_0144 after REQ-033 -> miss, refill index 2, new tag; pc=32'h44 then misses again, misscnt=3.
REQ-036 Flush: flush=1 in IDLE, then pc=32'h44 -> miss; flush asserted during a fill -> following re-lookup misses, two fills total.
REQ-037 Reset at 4th beat of a fill -> instrreq=0 next cycle, cpuready never pulses, subsequent same pc misses.
REQ-038 Saturation: force 65536 fills (or preload counter) -> misscnt stays 16'hFFFF.

Source files
------------

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped instruction cache with 8-word line refill.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cpureq, pc          CPU fetch request (level) and byte address
//   cpuready, cpuinstr  one-cycle response pulse and fetched word
//   flush               invalidate all lines (deferred while a fill is running)
//   instrreq, instradr  burst request and line-aligned base address to memory
//   instrval, instr     memory beat valid and data, ascending word order
//   misscnt             saturating count of completed fills
module icache_fill #(
    parameter int unsigned LINES         = 8,
    parameter logic [15:0] MISSCNT_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpureq,
    input  logic [31:0] pc,
    output logic        cpuready,
    output logic [31:0] cpuinstr,
    input  logic        flush,
    output logic        instrreq,
    output logic [31:0] instradr,
    input  logic        instrval,
    input  logic [31:0] instr,
    output logic [15:0] misscnt
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - 5 - IDX_W;
    localparam int unsigned ADR_W = IDX_W + 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Registered state
    state_t             state_q,      state_d;
    logic               cpuready_q,   cpuready_d;
    logic [31:0]        cpuinstr_q,   cpuinstr_d;
    logic               instrreq_q,   instrreq_d;
    logic [31:0]        instradr_q,   instradr_d;
    logic [15:0]        misscnt_q,    misscnt_d;
    logic [LINES-1:0]   valid_q,      valid_d;
    logic [2:0]         beat_q,       beat_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]   idx_q,        idx_d;
    logic [TAG_W-1:0]   tag_q,        tag_d;

    // Storage arrays (never reset)
    logic [31:0]        data_mem [LINES*8];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    // Lookup path
    logic [IDX_W-1:0]   pc_idx_c;
    logic [TAG_W-1:0]   pc_tag_c;
    logic [2:0]         pc_off_c;
    logic [31:0]        rd_word_c;
    logic               inval_c;
    logic               hit_c;
    logic               data_we_c;
    logic               tag_we_c;
    logic               unused_pc_bits;

    assign pc_off_c       = pc[4:2];
    assign pc_idx_c       = pc[5 +: IDX_W];
    assign pc_tag_c       = pc[31 -: TAG_W];
    assign unused_pc_bits = ^pc[1:0];
    assign rd_word_c      = data_mem[{pc_idx_c, pc_off_c}];

    // Any flush seen now (or deferred from a fill) wins over a hit this edge
    assign inval_c = flush | flush_pend_q;
    assign hit_c   = valid_q[pc_idx_c] && (tag_mem[pc_idx_c] == pc_tag_c) && !inval_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cpuready_q   <= 1'b0;
            cpuinstr_q   <= 32'h0;
            instrreq_q   <= 1'b0;
            instradr_q   <= 32'h0;
            misscnt_q    <= MISSCNT_RESET;
            valid_q      <= '0;
            beat_q       <= 3'd0;
            flush_pend_q <= 1'b0;
            idx_q        <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            cpuready_q   <= cpuready_d;
            cpuinstr_q   <= cpuinstr_d;
            instrreq_q   <= instrreq_d;
            instradr_q   <= instradr_d;
            misscnt_q    <= misscnt_d;
            valid_q      <= valid_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
        end
    end

    // Data/tag array writes
    always_ff @(posedge clk) begin
        if (data_we_c) begin
            data_mem[ADR_W'({idx_q, beat_q})] <= instr;
        end
        if (tag_we_c) begin
            tag_mem[idx_q] <= tag_q;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cpuready_d   = 1'b0;
        cpuinstr_d   = cpuinstr_q;
        instrreq_d   = instrreq_q;
        instradr_d   = instradr_q;
        misscnt_d    = misscnt_q;
        valid_d      = valid_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        data_we_c    = 1'b0;
        tag_we_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inval_c) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
                if (cpureq) begin
                    if (hit_c) begin
                        cpuready_d = 1'b1;
                        cpuinstr_d = rd_word_c;
                    end else begin
                        state_d    = FILL;
                        instrreq_d = 1'b1;
                        instradr_d = {pc[31:5], 5'b0};
                        beat_d     = 3'd0;
                        idx_d      = pc_idx_c;
                        tag_d      = pc_tag_c;
                    end
                end
            end
            FILL: begin
                // Flushes during a fill are deferred to the first IDLE edge
                flush_pend_d = flush_pend_q | flush;
                if (instrval) begin
                    data_we_c = 1'b1;
                    beat_d    = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d        = IDLE;
                        instrreq_d     = 1'b0;
                        valid_d[idx_q] = 1'b1;
                        tag_we_c       = 1'b1;
                        misscnt_d      = (misscnt_q == 16'hFFFF) ? misscnt_q
                                                                 : misscnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpuready = cpuready_q;
    assign cpuinstr = cpuinstr_q;
    assign instrreq = instrreq_q;
    assign instradr = instradr_q;
    assign misscnt  = misscnt_q;

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: directed + randomized bench for icache_fill.
// A second instance whose miss counter resets near its ceiling shares all
// stimulus with the main instance to exercise counter saturation.
module tb_icache_fill;

    localparam int unsigned LINES = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TAG_W = 24;
    localparam logic [15:0] SAT_RESET = 16'hFFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpureq;
    logic [31:0] pc;
    logic        flush;
    logic        instrval = 1'b0;
    logic [31:0] instr = 32'h0;

    logic        cpuready,  cpuready2;
    logic [31:0] cpuinstr,  cpuinstr2;
    logic        instrreq,  instrreq2;
    logic [31:0] instradr,  instradr2;
    logic [15:0] misscnt,   misscnt2;

    int errors = 0;
    int checks = 0;

    // Reference model: per-line valid/tag and fill counters
    bit   [LINES-1:0] mvalid;
    logic [TAG_W-1:0] mtag [LINES];
    int               mcnt;
    int               mcnt2;

    icache_fill #(.LINES(LINES)) dut (
        .clk(clk), .reset(reset), .cpureq(cpureq), .pc(pc),
        .cpuready(cpuready), .cpuinstr(cpuinstr), .flush(flush),
        .instrreq(instrreq), .instradr(instradr), .instrval(instrval),
        .instr(instr), .misscnt(misscnt)
    );

    icache_fill #(.LINES(LINES), .MISSCNT_RESET(SAT_RESET)) dut_sat (
        .clk(clk), .reset(reset), .cpureq(cpureq), .pc(pc),
        .cpuready(cpuready2), .cpuinstr(cpuinstr2), .flush(flush),
        .instrreq(instrreq2), .instradr(instradr2), .instrval(instrval),
        .instr(instr), .misscnt(misscnt2)
    );

    always #5 clk = ~clk;

    // Memory contents: 32'h1000_0000 + word for line 0x40, scrambled elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] line;
        line = (a & 32'hFFFF_FFE0) - 32'h40;
        return 32'h1000_0000 + 32'(a[4:2]) + line * 32'h9E37_79B1;
    endfunction

    // Memory stage: sees instrreq one edge after it rises, then 8 beats
    int mem_n = 0;
    always @(posedge clk) begin
        if (reset)         mem_n <= 0;
        else if (instrreq) mem_n <= mem_n + 1;
        else               mem_n <= 0;
    end
    always @(negedge clk) begin
        if (mem_n >= 2 && mem_n <= 9) begin
            instrval <= 1'b1;
            instr    <= mem_word(instradr | 32'((mem_n - 2) << 2));
        end else begin
            instrval <= 1'b0;
            instr    <= $urandom;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        mvalid = '0;
        mcnt   = 0;
        mcnt2  = int'(SAT_RESET);
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush  = 1'b0;
        mvalid = '0;
    endtask

    // One CPU request; fl_now flushes with the request, fl_mid>0 flushes
    // on that edge count of a resulting fill. Called and returns at a negedge.
    task automatic do_req(input logic [31:0] a, input bit fl_now, input int fl_mid_in);
        int               idx, fills, exp_lat, fl_mid, cyc;
        int               lat, lat2, rq, rq2;
        logic [TAG_W-1:0] tg;
        logic [31:0]      got, got2, exp_data, base;
        bit               hit, adr_ok, adr_ok2;

        idx = int'(a[5 +: IDX_W]);
        tg  = a[31 -: TAG_W];
        if (fl_now) mvalid = '0;
        hit     = mvalid[idx] && (mtag[idx] == tg);
        fl_mid  = hit ? 0 : fl_mid_in;
        fills   = hit ? 0 : ((fl_mid > 0) ? 2 : 1);
        exp_lat = hit ? 1 : 12 + 11 * (fills - 1);
        if (!hit) begin
            if (fl_mid > 0) mvalid = '0;
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
        mcnt     = sat16(mcnt + fills);
        mcnt2    = sat16(mcnt2 + fills);
        exp_data = mem_word(a);
        base     = a & 32'hFFFF_FFE0;

        pc = a; cpureq = 1'b1; flush = fl_now;
        cyc = 0; lat = 0; lat2 = 0; rq = 0; rq2 = 0;
        got = 32'h0; got2 = 32'h0; adr_ok = 1'b1; adr_ok2 = 1'b1;
        while (lat == 0 && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            flush = (cyc == fl_mid);
            if (instrreq) begin
                rq++;
                if (instradr !== base) adr_ok = 1'b0;
            end
            if (instrreq2) begin
                rq2++;
                if (instradr2 !== base) adr_ok2 = 1'b0;
            end
            if (cpuready2 === 1'b1 && lat2 == 0) begin
                lat2 = cyc; got2 = cpuinstr2;
            end
            if (cpuready === 1'b1) begin
                lat = cyc; got = cpuinstr; cpureq = 1'b0;
            end
        end
        flush = 1'b0; cpureq = 1'b0;

        check("latency",       32'(lat),     32'(exp_lat));
        check("cpuinstr",      got,          exp_data);
        check("instrreq_cyc",  32'(rq),      32'(10 * fills));
        check("instradr",      32'(adr_ok),  32'd1);
        check("misscnt",       32'(misscnt), 32'(mcnt));
        check("sat_latency",   32'(lat2),    32'(exp_lat));
        check("sat_cpuinstr",  got2,         exp_data);
        check("sat_instrreq",  32'(rq2),     32'(10 * fills));
        check("sat_instradr",  32'(adr_ok2), 32'd1);
        check("sat_misscnt",   32'(misscnt2), 32'(mcnt2));
        @(posedge clk);
        @(negedge clk);
        check("ready_pulse",   32'(cpuready), 32'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; cpureq = 1'b0; pc = 32'h0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpuready", 32'(cpuready), 32'd0);
        check("rst_cpuinstr", cpuinstr,      32'h0);
        check("rst_instrreq", 32'(instrreq), 32'd0);
        check("rst_instradr", instradr,      32'h0);
        check("rst_misscnt",  32'(misscnt),  32'd0);
        check("rst_sat_cnt",  32'(misscnt2), 32'(SAT_RESET));
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, hit in the same line, conflict eviction
        do_req(32'h0000_0044, 1'b0, 0);
        do_req(32'h0000_005C, 1'b0, 0);
        do_req(32'h0000_0144, 1'b0, 0);
        do_req(32'h0000_0044, 1'b0, 0);
        check("conflict_cnt", 32'(misscnt), 32'd3);

        // Flush in IDLE, flush with request, flush during a fill
        idle_flush();
        do_req(32'h0000_0044, 1'b0, 0);
        do_req(32'h0000_0048, 1'b1, 0);
        do_req(32'h0000_0144, 1'b0, 4);
        do_req(32'h0000_0150, 1'b0, 0);

        // Reset on the edge of the fourth beat
        pc = 32'h0000_0064; cpureq = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (cpuready === 1'b1) pulses++;
            if (c == 6) begin
                check("pre_rst_req", 32'(instrreq), 32'd1);
                reset = 1'b1;
            end
        end
        check("abort_instrreq", 32'(instrreq), 32'd0);
        check("abort_misscnt",  32'(misscnt),  32'd0);
        reset = 1'b0; cpureq = 1'b0;
        model_reset();
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (cpuready === 1'b1) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'd0);
        do_req(32'h0000_0064, 1'b0, 0);

        // Saturation on the near-full counter instance
        do_req(32'h0000_0084, 1'b0, 0);
        do_req(32'h0000_00A4, 1'b0, 0);
        do_req(32'h0000_00C4, 1'b0, 0);
        check("saturated", 32'(misscnt2), 32'h0000_FFFF);

        // Randomized traffic over a small address pool
        for (int n = 0; n < 40; n++) begin
            logic [TAG_W-1:0] tg;
            logic [31:0]      a;
            int               sel, fm;
            bit               fn;
            sel = int'($urandom_range(0, 2));
            tg  = (sel == 0) ? 24'h0 : ((sel == 1) ? 24'h1 : 24'h80_0000);
            a   = {tg, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            fn  = ($urandom_range(0, 7) == 0);
            fm  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 0;
            if ($urandom_range(0, 9) == 0) idle_flush();
            do_req(a, fn, fm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
